pipeline_hazard_ctrl: RTL and testbench
=======================================

Name: pipeline_hazard_ctrl

Overview:
- Sequences the five-stage pipeline's stall, bubble and flush controls, complementing the forwarding mux selection.
- Resolves three hazard classes:
  - load-use hazards the forwarding paths cannot cover;
  - taken-branch redirects resolved in execute;
  - multi-cycle data-memory accesses held in the mem stage.
- Sits beside the pipeline registers. Drives their enable and clear inputs from a small state machine plus per-cycle detection.

Parameters:
- REDIRECT_CYCLES, 2: total cycles flush_decode stays asserted after a taken branch. Legal range 1..7; covers fetch-side latency.
- MEM_TIMEOUT, 255: consecutive data-memory wait cycles before mem_timeout is raised. Legal range 1..255.

Ports:
- clk  in  1  pipeline clock
- rst  in  1  asynchronous active-high reset
- rs1_addr_decode  in  5  rs1 of the instruction in decode
- rs2_addr_decode  in  5  rs2 of the instruction in decode
- rs1_used_decode  in  1  decode instruction reads rs1
- rs2_used_decode  in  1  decode instruction reads rs2
- rd_addr_execute  in  5  rd of the instruction in execute
- mem_read_execute  in  1  execute instruction is a load
- branch_taken_execute  in  1  execute redirects the PC this cycle
- dmem_req_mem  in  1  mem stage holds a load/store access
- dmem_ready  in  1  data memory completes the access this cycle
- stall_fetch  out  1  hold the PC and the IF/ID register
- stall_decode  out  1  hold the ID/EX source (decode) contents
- stall_execute  out  1  hold the EX/MEM register
- stall_mem  out  1  hold the MEM/WB input
- flush_decode  out  1  clear IF/ID to NOP at the next edge
- bubble_execute  out  1  load NOP into ID/EX at the next edge
- bubble_wb  out  1  load NOP into MEM/WB at the next edge
- mem_timeout  out  1  sticky memory-timeout error flag

Behaviour:
- States: RUN, MEM_WAIT, REDIRECT. Registered: state, redirect_cnt (3b), wait_cnt (8b), mem_timeout.
- While rst is high: state=RUN, counters=0, mem_timeout=0, and every output is 0. Stall, bubble and flush outputs are combinational from state and inputs; zero latency.
- Memory-wait rule (highest priority):
  - Applies when dmem_req_mem=1 and dmem_ready=0, in any state.
  - Asserts stall_fetch, stall_decode, stall_execute, stall_mem and bubble_wb.
  - Branch and load-use outputs are suppressed that cycle.
  - Next state is MEM_WAIT; wait_cnt increments, saturating at 255.
- MEM_WAIT: the same outputs hold while dmem_ready=0. When dmem_ready=1:
  - no stall outputs are asserted that cycle;
  - wait_cnt clears;
  - the next state is RUN, or REDIRECT if a redirect count was pending.
- Timeout: when wait_cnt reaches MEM_TIMEOUT, mem_timeout goes to 1 and stays set until rst. The stall continues; there is no abort.
- Branch, in RUN and not memory-stalled, with branch_taken_execute=1:
  - flush_decode=1 and bubble_execute=1;
  - load-use detection is ignored.
  - If REDIRECT_CYCLES>1: next state is REDIRECT with redirect_cnt=REDIRECT_CYCLES-1.
- REDIRECT:
  - Outputs: flush_decode=1, bubble_execute=1; load-use detection is suppressed.
  - redirect_cnt decrements each unstalled cycle; return to RUN when it reaches 0.
  - A memory stall freezes redirect_cnt (state recorded as MEM_WAIT, count kept).
  - A new taken branch reloads redirect_cnt to REDIRECT_CYCLES-1.
- Load-use, in RUN only:
  - Condition: mem_read_execute=1, rd_addr_execute!=0, and (rs1_used_decode & rs1==rd) or (rs2_used_decode & rs2==rd).
  - Outputs: stall_fetch=1, stall_decode=1, bubble_execute=1 for exactly that cycle; no state change.
  - The load advances into mem, so the condition clears the next cycle.
- Register x0 never creates a load-use hazard.
- Async rst asserted mid-MEM_WAIT or mid-REDIRECT: immediate return to the reset values above.

Optional Feature:
- Macro: HAZARD_PERF_EN.
- When defined, adds outputs perf_stall_cycles[31:0], perf_loaduse_events[31:0], perf_redirect_events[31:0]:
  - perf_stall_cycles: cycles with stall_fetch=1;
  - perf_loaduse_events: load-use bubbles;
  - perf_redirect_events: taken branches accepted.
- All three counters are wrapping, cleared by rst, and do not affect control behaviour.
- When undefined, the ports and counters are absent; everything else is identical.

Test Plan:
- Load-use: rd_addr_execute=5, mem_read_execute=1, rs2_addr_decode=5, rs2_used_decode=1 -> that cycle stall_fetch=stall_decode=bubble_execute=1; next cycle (mem_read_execute=0) all 0.
- x0 / unused source: rd_addr_execute=0 with rs1=0 used, then rd_addr_execute=7 with rs1=7 and rs1_used_decode=0 -> no stall in either case.
- Redirect: REDIRECT_CYCLES=2, branch_taken_execute pulse for one cycle -> flush_decode=bubble_execute=1 for exactly 2 cycles, then RUN.
- Memory wait: dmem_req_mem=1 with dmem_ready low for 3 cycles then high:
  - all four stalls and bubble_wb high for 3 cycles;
  - 0 on the ready cycle; mem_timeout stays 0.
- Timeout: MEM_TIMEOUT=4, dmem_ready low 10 cycles -> mem_timeout rises after 4 wait cycles and stays 1 after ready, until rst pulse clears it.
- Collision: taken branch during REDIRECT's second cycle combined with a 2-cycle memory stall -> redirect_cnt frozen during the stall, reloaded by the branch, flush_decode total matches the reload count once unstalled.

Source files
------------

// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl
// Stall, bubble and flush sequencing for the five-stage pipeline. It covers
// three cases: load-use hazards that forwarding cannot resolve, taken-branch
// redirects resolved in execute, and multi-cycle data-memory accesses held in
// the mem stage. A small state machine remembers in-progress redirects and
// memory waits. Hazards detected in the current cycle drive the outputs
// combinationally, so there is no added latency.
//
// Parameters:
//   REDIRECT_CYCLES  cycles flush_decode stays high after a taken branch (1..7)
//   MEM_TIMEOUT      consecutive memory wait cycles before mem_timeout (1..255)
//
// Ports:
//   clk, rst                          clock, async active-high reset
//   rs1/rs2_addr_decode, rs*_used     decode-stage source registers and use flags
//   rd_addr_execute, mem_read_execute execute-stage destination / load flag
//   branch_taken_execute              execute redirects the PC this cycle
//   dmem_req_mem, dmem_ready          mem-stage access and its completion
//   stall_fetch/decode/execute/mem    pipeline register holds
//   flush_decode                      clear IF/ID to NOP
//   bubble_execute, bubble_wb         insert NOP into ID/EX, MEM/WB
//   mem_timeout                       sticky memory-timeout flag
//
// Optional feature (macro HAZARD_PERF_EN): adds the wrapping performance
// counters perf_stall_cycles, perf_loaduse_events and perf_redirect_events.

module pipeline_hazard_ctrl #(
    parameter int REDIRECT_CYCLES = 2,
    parameter int MEM_TIMEOUT     = 255
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [4:0] rs1_addr_decode,
    input  logic [4:0] rs2_addr_decode,
    input  logic       rs1_used_decode,
    input  logic       rs2_used_decode,
    input  logic [4:0] rd_addr_execute,
    input  logic       mem_read_execute,
    input  logic       branch_taken_execute,
    input  logic       dmem_req_mem,
    input  logic       dmem_ready,
    output logic       stall_fetch,
    output logic       stall_decode,
    output logic       stall_execute,
    output logic       stall_mem,
    output logic       flush_decode,
    output logic       bubble_execute,
    output logic       bubble_wb,
    output logic       mem_timeout
`ifdef HAZARD_PERF_EN
    ,
    output logic [31:0] perf_stall_cycles,
    output logic [31:0] perf_loaduse_events,
    output logic [31:0] perf_redirect_events
`endif
);

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        REDIRECT = 2'd2
    } state_t;

    localparam logic [2:0] REDIRECT_RELOAD = 3'(REDIRECT_CYCLES - 1);
    localparam logic [7:0] TIMEOUT_LIMIT   = 8'(MEM_TIMEOUT);

    state_t     state, state_next, resume_state;
    logic [2:0] redirect_cnt, redirect_cnt_next;
    logic [7:0] wait_cnt, wait_cnt_next;
    logic       mem_stall;
    logic       load_use;
    logic       load_use_bubble;
    logic       branch_accept;
    logic       timeout_hit;

    // State register, counters and the sticky timeout flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= RUN;
            redirect_cnt <= 3'd0;
            wait_cnt     <= 8'd0;
            mem_timeout  <= 1'b0;
        end else begin
            state        <= state_next;
            redirect_cnt <= redirect_cnt_next;
            wait_cnt     <= wait_cnt_next;
            if (timeout_hit) begin
                mem_timeout <= 1'b1;
            end
        end
    end

    // Hazard detection, next-state logic and the control outputs.
    // When a memory wait ends, that cycle behaves like the state being resumed.
    // A pending redirect therefore keeps flushing, and a branch that was held
    // in execute during the stall is accepted on the release cycle.
    always_comb begin
        state_next        = state;
        redirect_cnt_next = redirect_cnt;
        wait_cnt_next     = wait_cnt;
        stall_fetch       = 1'b0;
        stall_decode      = 1'b0;
        stall_execute     = 1'b0;
        stall_mem         = 1'b0;
        flush_decode      = 1'b0;
        bubble_execute    = 1'b0;
        bubble_wb         = 1'b0;
        load_use_bubble   = 1'b0;
        branch_accept     = 1'b0;
        timeout_hit       = 1'b0;

        mem_stall = !dmem_ready && (dmem_req_mem || (state == MEM_WAIT));

        load_use = mem_read_execute && (rd_addr_execute != 5'd0) &&
                   ((rs1_used_decode && (rs1_addr_decode == rd_addr_execute)) ||
                    (rs2_used_decode && (rs2_addr_decode == rd_addr_execute)));

        if (state == MEM_WAIT) begin
            resume_state = (redirect_cnt != 3'd0) ? REDIRECT : RUN;
        end else begin
            resume_state = state;
        end

        if (mem_stall) begin
            stall_fetch   = 1'b1;
            stall_decode  = 1'b1;
            stall_execute = 1'b1;
            stall_mem     = 1'b1;
            bubble_wb     = 1'b1;
            state_next    = MEM_WAIT;
            wait_cnt_next = (wait_cnt == 8'hFF) ? wait_cnt : wait_cnt + 8'd1;
            timeout_hit   = (wait_cnt_next >= TIMEOUT_LIMIT);
        end else begin
            wait_cnt_next = 8'd0;
            state_next    = RUN;
            if (branch_taken_execute) begin
                flush_decode      = 1'b1;
                bubble_execute    = 1'b1;
                branch_accept     = 1'b1;
                redirect_cnt_next = REDIRECT_RELOAD;
                state_next        = (REDIRECT_RELOAD != 3'd0) ? REDIRECT : RUN;
            end else if (resume_state == REDIRECT) begin
                flush_decode      = 1'b1;
                bubble_execute    = 1'b1;
                redirect_cnt_next = redirect_cnt - 3'd1;
                state_next        = (redirect_cnt == 3'd1) ? RUN : REDIRECT;
            end else if (load_use) begin
                stall_fetch     = 1'b1;
                stall_decode    = 1'b1;
                bubble_execute  = 1'b1;
                load_use_bubble = 1'b1;
            end
        end

        if (rst) begin
            stall_fetch     = 1'b0;
            stall_decode    = 1'b0;
            stall_execute   = 1'b0;
            stall_mem       = 1'b0;
            flush_decode    = 1'b0;
            bubble_execute  = 1'b0;
            bubble_wb       = 1'b0;
            load_use_bubble = 1'b0;
            branch_accept   = 1'b0;
        end
    end

`ifdef HAZARD_PERF_EN
    // Wrapping event counters. They only observe the control outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_stall_cycles    <= 32'd0;
            perf_loaduse_events  <= 32'd0;
            perf_redirect_events <= 32'd0;
        end else begin
            if (stall_fetch) begin
                perf_stall_cycles <= perf_stall_cycles + 32'd1;
            end
            if (load_use_bubble) begin
                perf_loaduse_events <= perf_loaduse_events + 32'd1;
            end
            if (branch_accept) begin
                perf_redirect_events <= perf_redirect_events + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// tb_pipeline_hazard_ctrl
// Self-checking bench for pipeline_hazard_ctrl (REDIRECT_CYCLES=2,
// MEM_TIMEOUT=4). The reference model tracks only four things: the number of
// flush cycles still owed, whether a memory wait is open, the wait length,
// and the sticky timeout flag. Expected outputs are derived from these with
// plain arithmetic.

module tb_pipeline_hazard_ctrl;

    localparam int R  = 2;
    localparam int MT = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [4:0] rs1_addr_decode, rs2_addr_decode, rd_addr_execute;
    logic       rs1_used_decode, rs2_used_decode, mem_read_execute;
    logic       branch_taken_execute, dmem_req_mem, dmem_ready;
    logic       stall_fetch, stall_decode, stall_execute, stall_mem;
    logic       flush_decode, bubble_execute, bubble_wb, mem_timeout;
    logic [7:0] obs;

    int checks = 0;
    int errors = 0;

    // Reference model state (current and next).
    int   m_left, m_wait, n_left, n_wait;
    bit   m_waiting, m_timeout, n_waiting, n_timeout;
    logic [7:0] exp_out;

    pipeline_hazard_ctrl #(.REDIRECT_CYCLES(R), .MEM_TIMEOUT(MT)) dut (
        .clk(clk), .rst(rst),
        .rs1_addr_decode(rs1_addr_decode), .rs2_addr_decode(rs2_addr_decode),
        .rs1_used_decode(rs1_used_decode), .rs2_used_decode(rs2_used_decode),
        .rd_addr_execute(rd_addr_execute), .mem_read_execute(mem_read_execute),
        .branch_taken_execute(branch_taken_execute),
        .dmem_req_mem(dmem_req_mem), .dmem_ready(dmem_ready),
        .stall_fetch(stall_fetch), .stall_decode(stall_decode),
        .stall_execute(stall_execute), .stall_mem(stall_mem),
        .flush_decode(flush_decode), .bubble_execute(bubble_execute),
        .bubble_wb(bubble_wb), .mem_timeout(mem_timeout)
    );

    always #5 clk = ~clk;

    assign obs = {stall_fetch, stall_decode, stall_execute, stall_mem,
                  flush_decode, bubble_execute, bubble_wb, mem_timeout};

    // Expected outputs for the current inputs, plus the next model state.
    // Bit order: sf sd se sm fd be bw mt.
    function void model_eval();
        bit stalled, lu;
        stalled = !dmem_ready && (dmem_req_mem || m_waiting);
        lu = mem_read_execute && (rd_addr_execute != 0) &&
             ((rs1_used_decode && rs1_addr_decode == rd_addr_execute) ||
              (rs2_used_decode && rs2_addr_decode == rd_addr_execute));
        n_left = m_left; n_wait = m_wait; n_waiting = m_waiting; n_timeout = m_timeout;
        exp_out = 8'b0;
        if (stalled) begin
            exp_out = 8'b1111_0010;
            n_waiting = 1;
            n_wait = (m_wait + 1 > 255) ? 255 : m_wait + 1;
            if (n_wait >= MT) n_timeout = 1;
        end else begin
            n_waiting = 0;
            n_wait = 0;
            if (branch_taken_execute) begin
                exp_out = 8'b0000_1100;
                n_left = R - 1;
            end else if (m_left > 0) begin
                exp_out = 8'b0000_1100;
                n_left = m_left - 1;
            end else if (lu) begin
                exp_out = 8'b1100_0100;
            end
        end
        exp_out[0] = m_timeout;
    endfunction

    function void model_reset();
        m_left = 0; m_wait = 0; m_waiting = 0; m_timeout = 0;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
        m_left = n_left; m_wait = n_wait; m_waiting = n_waiting; m_timeout = n_timeout;
    endtask

    task automatic applyStimulus(input logic [4:0] rs1, input logic [4:0] rs2,
                                 input logic u1, input logic u2, input logic [4:0] rd,
                                 input logic mr, input logic br, input logic req,
                                 input logic rdy);
        rs1_addr_decode = rs1; rs2_addr_decode = rs2;
        rs1_used_decode = u1;  rs2_used_decode = u2;
        rd_addr_execute = rd;  mem_read_execute = mr;
        branch_taken_execute = br; dmem_req_mem = req; dmem_ready = rdy;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
    endtask

    task automatic test_reset();
        applyStimulus(5'd5, 5'd5, 1, 1, 5'd5, 1, 1, 1, 0);
        rst = 1'b1;
        #2;
        checks++;
        if (obs !== 8'b0) begin
            errors++;
            $display("[TB] FAIL reset_outputs: got %b expected %b", obs, 8'b0);
        end
        @(posedge clk);
        #1;
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 1);
        rst = 1'b0;
        model_reset();
        #2;
        model_eval();
        checks++;
        if (obs !== exp_out) begin
            errors++;
            $display("[TB] FAIL reset_idle: got %b expected %b", obs, exp_out);
        end
        tick();
    endtask

    task automatic test_load_use();
        for (int i = 0; i < 2; i++) begin
            if (i == 0) applyStimulus(5'd3, 5'd5, 0, 1, 5'd5, 1, 0, 0, 1);
            else        applyStimulus(5'd3, 5'd5, 0, 1, 5'd5, 0, 0, 0, 1);
            #2;
            model_eval();
            checks++;
            if (obs !== exp_out) begin
                errors++;
                $display("[TB] FAIL load_use cycle %0d: got %b expected %b", i, obs, exp_out);
            end
            tick();
        end
    endtask

    task automatic test_x0_unused();
        for (int i = 0; i < 2; i++) begin
            if (i == 0) applyStimulus(5'd0, 5'd9, 1, 0, 5'd0, 1, 0, 0, 1);
            else        applyStimulus(5'd7, 5'd9, 0, 0, 5'd7, 1, 0, 0, 1);
            #2;
            checks++;
            if (obs !== 8'b0) begin
                errors++;
                $display("[TB] FAIL x0_unused cycle %0d: got %b expected %b", i, obs, 8'b0);
            end
            tick();
        end
    endtask

    task automatic test_redirect();
        int flushes = 0;
        for (int i = 0; i < 5; i++) begin
            applyStimulus(0, 0, 0, 0, 0, 0, (i == 0), 0, 1);
            #2;
            model_eval();
            if (flush_decode === 1'b1) flushes++;
            checks++;
            if (obs !== exp_out) begin
                errors++;
                $display("[TB] FAIL redirect cycle %0d: got %b expected %b", i, obs, exp_out);
            end
            tick();
        end
        checks++;
        if (flushes != R) begin
            errors++;
            $display("[TB] FAIL redirect_len: got %0d expected %0d", flushes, R);
        end
    endtask

    task automatic test_mem_wait();
        for (int i = 0; i < 6; i++) begin
            applyStimulus(0, 0, 0, 0, 0, 0, 0, (i < 4), (i >= 3));
            #2;
            model_eval();
            checks++;
            if (obs !== exp_out) begin
                errors++;
                $display("[TB] FAIL mem_wait cycle %0d: got %b expected %b", i, obs, exp_out);
            end
            tick();
        end
    endtask

    task automatic test_timeout();
        for (int i = 0; i < 13; i++) begin
            applyStimulus(0, 0, 0, 0, 0, 0, 0, (i <= 10), (i >= 10));
            #2;
            model_eval();
            checks++;
            if (obs !== exp_out) begin
                errors++;
                $display("[TB] FAIL timeout cycle %0d: got %b expected %b", i, obs, exp_out);
            end
            tick();
        end
        checks++;
        if (mem_timeout !== 1'b1) begin
            errors++;
            $display("[TB] FAIL timeout_sticky: got %b expected 1", mem_timeout);
        end
        do_reset();
        #1;
        checks++;
        if (mem_timeout !== 1'b0) begin
            errors++;
            $display("[TB] FAIL timeout_cleared: got %b expected 0", mem_timeout);
        end
    endtask

    task automatic test_collision();
        int flushes = 0;
        for (int i = 0; i < 8; i++) begin
            case (i)
                0:       applyStimulus(0, 0, 0, 0, 0, 0, 1, 0, 1);
                1, 2:    applyStimulus(0, 0, 0, 0, 0, 0, 1, 1, 0);
                3:       applyStimulus(0, 0, 0, 0, 0, 0, 1, 1, 1);
                default: applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 1);
            endcase
            #2;
            model_eval();
            if (i >= 3 && flush_decode === 1'b1) flushes++;
            checks++;
            if (obs !== exp_out) begin
                errors++;
                $display("[TB] FAIL collision cycle %0d: got %b expected %b", i, obs, exp_out);
            end
            tick();
        end
        checks++;
        if (flushes != R) begin
            errors++;
            $display("[TB] FAIL collision_flush_total: got %0d expected %0d", flushes, R);
        end
    endtask

    task automatic test_async_reset_mid();
        for (int k = 0; k < 2; k++) begin
            if (k == 0) applyStimulus(0, 0, 0, 0, 0, 0, 1, 0, 1);
            else        applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 0);
            #2;
            model_eval();
            tick();
            applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
            #2;
            rst = 1'b1;
            #1;
            checks++;
            if (obs !== 8'b0) begin
                errors++;
                $display("[TB] FAIL async_reset_mid %0d: got %b expected %b", k, obs, 8'b0);
            end
            @(posedge clk);
            #1;
            rst = 1'b0;
            model_reset();
            #2;
            model_eval();
            checks++;
            if (obs !== exp_out) begin
                errors++;
                $display("[TB] FAIL after_reset_mid %0d: got %b expected %b", k, obs, exp_out);
            end
            tick();
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            applyStimulus(5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                          1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                          5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                          ($urandom_range(0, 7) == 0), ($urandom_range(0, 3) == 0),
                          1'($urandom_range(0, 1)));
            #2;
            model_eval();
            checks++;
            if (obs !== exp_out) begin
                errors++;
                $display("[TB] FAIL random cycle %0d: got %b expected %b", i, obs, exp_out);
            end
            tick();
        end
    endtask

    initial begin
        model_reset();
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 1);
        @(posedge clk);
        #1;
        test_reset();
        test_load_use();
        test_x0_unused();
        test_redirect();
        test_mem_wait();
        test_timeout();
        test_collision();
        test_async_reset_mid();
        do_reset();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
